// File: rtl/uart_cmd_interpreter.sv
// Assembles MSB-first command words from the UART RX FIFO, executes the opcode, replies via TX FIFO.
// Latency: NB byte pops (2 cycles each) + DECODE + execution + one TX byte every 2+ cycles.
// Backpressure: holds while uart_tx_full; RX bytes stay in the FIFO until the FSM is back in IDLE/RX_WAIT.
module uart_cmd_interpreter #(
    parameter int DATA_WIDTH   = 32,
    parameter int PULSE_BITS   = 12,
    parameter int RESET_CYCLES = 4,
    parameter int RX_TIMEOUT   = 250000,
    parameter int ACK_EN       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx_empty,
    input  logic                  uart_tx_full,
    input  logic [7:0]            uart_in,
    output logic                  read_uart,
    output logic                  write_uart,
    output logic [7:0]            uart_out,
    input  logic [DATA_WIDTH-1:0] processor_alu_result,
    input  logic [DATA_WIDTH-1:0] processor_reg_data,
    output logic                  processor_reset,
    output logic [4:0]            processor_reg_number,
    output logic [DATA_WIDTH-1:0] processor_reg_write_data,
    output logic                  processor_reg_write,
    output logic                  clk_enable,
    output logic [PULSE_BITS-1:0] num_pulses,
    output logic                  write_pulse,
    output logic                  busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] ACK_WORD  = {8'h06, {(DATA_WIDTH-8){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] NACK_WORD = {8'h15, {(DATA_WIDTH-8){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, RX_WAIT, RX_CAPTURE, DECODE, RESET_HOLD, REG_SETUP, TX_SEND
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [3:0]              byte_cnt;
    logic [3:0]              tx_left;
    logic [TW-1:0]           tmo_cnt;
    logic [RW-1:0]           rst_cnt;
    logic                    data_phase;
    logic                    setup_wait;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= IDLE;
            word                     <= '0;
            tx_shift                 <= '0;
            byte_cnt                 <= '0;
            tx_left                  <= '0;
            tmo_cnt                  <= '0;
            rst_cnt                  <= '0;
            data_phase               <= 1'b0;
            setup_wait               <= 1'b0;
            read_uart                <= 1'b0;
            write_uart               <= 1'b0;
            uart_out                 <= '0;
            processor_reset          <= 1'b0;
            processor_reg_number     <= '0;
            processor_reg_write_data <= '0;
            processor_reg_write      <= 1'b0;
            clk_enable               <= 1'b1;
            num_pulses               <= '0;
            write_pulse              <= 1'b0;
        end else begin
            write_pulse         <= 1'b0;
            processor_reg_write <= 1'b0;
            case (state)
                IDLE: if (!uart_rx_empty) state <= RX_WAIT;
                RX_WAIT: begin
                    if (!uart_rx_empty) begin
                        read_uart <= 1'b1;
                        state     <= RX_CAPTURE;
                    end else if (byte_cnt != 0 || data_phase) begin
                        // A stalled partial word (or a missing data word) is dropped silently
                        if (tmo_cnt == TW'(RX_TIMEOUT - 1)) begin
                            byte_cnt   <= '0;
                            data_phase <= 1'b0;
                            tmo_cnt    <= '0;
                            state      <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                RX_CAPTURE: begin
                    // First cycle is the pop strobe; the FIFO data is valid on the second
                    if (read_uart) begin
                        read_uart <= 1'b0;
                    end else begin
                        word    <= {word[DATA_WIDTH-9:0], uart_in};
                        tmo_cnt <= '0;
                        if (byte_cnt == 4'(NB - 1)) begin
                            byte_cnt <= '0;
                            state    <= DECODE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= RX_WAIT;
                        end
                    end
                end
                DECODE: begin
                    tx_shift <= ACK_WORD;
                    tx_left  <= 4'd1;
                    state    <= (ACK_EN != 0) ? TX_SEND : IDLE;
                    if (data_phase) begin
                        data_phase               <= 1'b0;
                        processor_reg_write_data <= word;
                        processor_reg_write      <= 1'b1;
                    end else begin
                        case (word[7:0])
                            8'h01: begin
                                processor_reset <= 1'b1;
                                rst_cnt         <= RW'(RESET_CYCLES - 1);
                                state           <= RESET_HOLD;
                            end
                            8'h02: clk_enable <= 1'b0;
                            8'h03: clk_enable <= 1'b1;
                            8'h04: begin
                                num_pulses  <= word[DATA_WIDTH-1 -: PULSE_BITS];
                                write_pulse <= (word[DATA_WIDTH-1 -: PULSE_BITS] != '0);
                            end
                            8'h05: begin
                                processor_reg_number <= word[12:8];
                                setup_wait           <= 1'b1;
                                state                <= REG_SETUP;
                            end
                            8'h06: begin
                                processor_reg_number <= word[12:8];
                                data_phase           <= 1'b1;
                                state                <= RX_WAIT;
                            end
                            8'h07: begin
                                tx_shift <= processor_alu_result;
                                tx_left  <= 4'(NB);
                                state    <= TX_SEND;
                            end
                            default: begin
                                tx_shift <= NACK_WORD;
                                state    <= TX_SEND;
                            end
                        endcase
                    end
                end
                RESET_HOLD: begin
                    if (rst_cnt == '0) begin
                        processor_reset <= 1'b0;
                        tx_shift        <= ACK_WORD;
                        tx_left         <= 4'd1;
                        state           <= (ACK_EN != 0) ? TX_SEND : IDLE;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                REG_SETUP: begin
                    // Register file needs a full cycle after the index changes
                    if (setup_wait) begin
                        setup_wait <= 1'b0;
                    end else begin
                        tx_shift <= processor_reg_data;
                        tx_left  <= 4'(NB);
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (write_uart) begin
                        write_uart <= 1'b0;
                        if (tx_left == 0) state <= IDLE;
                    end else if (tx_left == 0) begin
                        state <= IDLE;
                    end else if (!uart_tx_full) begin
                        write_uart <= 1'b1;
                        uart_out   <= tx_shift[DATA_WIDTH-1 -: 8];
                        tx_shift   <= tx_shift << 8;
                        tx_left    <= tx_left - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_interpreter.sv
// Directed bench for uart_cmd_interpreter with RX/TX FIFO and register-file models plus scoreboards.
module tb_uart_cmd_interpreter;
    localparam int DW = 32;
    localparam int PB = 12;
    localparam int RC = 4;
    localparam int TO = 40;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          uart_rx_empty = 1'b1;
    logic          uart_tx_full = 1'b0;
    logic [7:0]    uart_in = '0;
    logic          read_uart, write_uart;
    logic [7:0]    uart_out;
    logic [DW-1:0] processor_alu_result = 32'h12345678;
    logic [DW-1:0] processor_reg_data = '0;
    logic          processor_reset;
    logic [4:0]    processor_reg_number;
    logic [DW-1:0] processor_reg_write_data;
    logic          processor_reg_write;
    logic          clk_enable;
    logic [PB-1:0] num_pulses;
    logic          write_pulse;
    logic          busy;

    always #5 clk = ~clk;

    uart_cmd_interpreter #(
        .DATA_WIDTH(DW), .PULSE_BITS(PB), .RESET_CYCLES(RC), .RX_TIMEOUT(TO), .ACK_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .uart_rx_empty(uart_rx_empty), .uart_tx_full(uart_tx_full), .uart_in(uart_in),
        .read_uart(read_uart), .write_uart(write_uart), .uart_out(uart_out),
        .processor_alu_result(processor_alu_result), .processor_reg_data(processor_reg_data),
        .processor_reset(processor_reset), .processor_reg_number(processor_reg_number),
        .processor_reg_write_data(processor_reg_write_data), .processor_reg_write(processor_reg_write),
        .clk_enable(clk_enable), .num_pulses(num_pulses), .write_pulse(write_pulse), .busy(busy)
    );

    logic [7:0]    rx_q[$];
    logic [7:0]    exp_tx[$];
    logic [PB-1:0] exp_pulse[$];
    logic [36:0]   exp_wr[$];
    int            exp_rst[$];
    logic [DW-1:0] regfile [32];
    int n_assert = 0, n_fail = 0;
    int tx_seen = 0, rd_seen = 0, pulse_seen = 0, rst_len = 0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RX FIFO: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (read_uart && rx_q.size() > 0) uart_in <= rx_q.pop_front();
        uart_rx_empty <= (rx_q.size() == 0);
        processor_reg_data <= regfile[processor_reg_number];
    end

    always @(negedge clk) begin
        if (write_uart) begin
            tx_seen++;
            check("tx_spacing", prev_wr, 0);
            check("tx_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) check("tx_byte", uart_out, exp_tx.pop_front());
        end
        prev_wr = write_uart;
        if (read_uart) begin
            rd_seen++;
            check("rd_spacing", prev_rd, 0);
        end
        prev_rd = read_uart;
        if (processor_reg_write) begin
            check("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0)
                check("wr_data", {processor_reg_number, processor_reg_write_data}, exp_wr.pop_front());
            regfile[processor_reg_number] = processor_reg_write_data;
        end
        if (write_pulse) begin
            pulse_seen++;
            check("pulse_expected", exp_pulse.size() != 0, 1);
            if (exp_pulse.size() != 0) check("pulse_num", num_pulses, exp_pulse.pop_front());
        end
        if (processor_reset) begin
            rst_len++;
        end else if (rst_len != 0) begin
            check("rst_expected", exp_rst.size() != 0, 1);
            if (exp_rst.size() != 0) check("rst_len", rst_len, exp_rst.pop_front());
            rst_len = 0;
        end
    end

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = NB - 1; i >= 0; i--) rx_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic expect_word(input logic [DW-1:0] w);
        for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(rx_q.size() == 0 && uart_rx_empty && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, n < 3000, 1);
        check({tag, "_sb_drained"}, exp_tx.size() + exp_wr.size() + exp_pulse.size() + exp_rst.size(), 0);
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (!write_uart && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_tx"}, write_uart, 1);
    endtask

    initial begin
        int p0, t0, hold_wr;
        for (int i = 0; i < 32; i++) regfile[i] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_clk_enable", clk_enable, 1);
        check("rst_busy", busy, 0);
        check("rst_read_uart", rd_seen, 0);
        check("rst_write_uart", write_uart, 0);
        check("rst_uart_out", uart_out, 0);
        check("rst_proc_reset", processor_reset, 0);
        check("rst_reg_number", processor_reg_number, 0);
        check("rst_reg_wdata", processor_reg_write_data, 0);
        check("rst_reg_write", processor_reg_write, 0);
        check("rst_pulses", {write_pulse, num_pulses}, 0);

        send_word(32'h0000_0002); exp_tx.push_back(8'h06); wait_idle("stop");
        check("stop_clk_enable", clk_enable, 0);
        send_word(32'h0000_0003); exp_tx.push_back(8'h06); wait_idle("start");
        check("start_clk_enable", clk_enable, 1);

        exp_pulse.push_back(12'h005);
        send_word(32'h0050_0004); exp_tx.push_back(8'h06); wait_idle("pulse5");
        check("pulse5_reg", num_pulses, 12'h005);
        p0 = pulse_seen;
        send_word(32'h0000_0004); exp_tx.push_back(8'h06); wait_idle("pulse0");
        check("pulse0_none", pulse_seen - p0, 0);
        check("pulse_clk_enable", clk_enable, 1);

        exp_wr.push_back({5'd10, 32'hDEAD_BEEF});
        send_word(32'h0000_0A06); send_word(32'hDEAD_BEEF); exp_tx.push_back(8'h06);
        wait_idle("write");
        check("write_reg_hold", processor_reg_number, 10);
        check("write_data_hold", processor_reg_write_data, 32'hDEAD_BEEF);

        expect_word(32'hDEAD_BEEF);
        send_word(32'h0000_0A05);
        wait_write("read");
        uart_tx_full = 1'b1;
        hold_wr = 0;
        repeat (20) begin
            @(negedge clk);
            hold_wr += int'(write_uart);
        end
        check("read_full_hold", hold_wr, 0);
        uart_tx_full = 1'b0;
        wait_idle("read");

        expect_word(32'h1234_5678);
        send_word(32'h0000_0007); wait_idle("alu");

        exp_rst.push_back(RC);
        send_word(32'h0000_0001); exp_tx.push_back(8'h06); wait_idle("preset");
        check("preset_low", processor_reset, 0);
        check("preset_clk_enable", clk_enable, 1);

        send_word(32'h0000_00FF); exp_tx.push_back(8'h15); wait_idle("nack");

        send_word(32'h0000_0002); exp_tx.push_back(8'h06); wait_idle("stop2");
        rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        repeat (TO + 20) @(negedge clk);
        check("tmo_idle", busy, 0);
        send_word(32'h0000_0003); exp_tx.push_back(8'h06); wait_idle("tmo_start");
        check("tmo_clk_enable", clk_enable, 1);

        send_word(32'h0000_0A06); rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        repeat (TO + 40) @(negedge clk);
        check("dtmo_idle", busy, 0);
        expect_word(32'hDEAD_BEEF);
        send_word(32'h0000_0A05); wait_idle("dtmo_read");

        send_word(32'h0000_0002); exp_tx.push_back(8'h06); wait_idle("stop3");
        expect_word(32'h1234_5678);
        send_word(32'h0000_0007);
        wait_write("midrst");
        @(negedge clk);
        reset = 1'b1;
        exp_tx.delete();
        rx_q.delete();
        t0 = tx_seen;
        repeat (3) @(negedge clk);
        check("midrst_write_low", write_uart, 0);
        check("midrst_clk_enable", clk_enable, 1);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_tx", tx_seen - t0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
